// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller port between the ROM download path (bytes packed into 32-bit words)
// and NUM_PORTS round-robin read requesters. One command in flight at most.
module sdram_arbiter #(
  parameter int NUM_PORTS  = 5,
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            ioctl_download,
  input  logic                            ioctl_wr,
  input  logic [ADDR_WIDTH+1:0]           ioctl_addr,
  input  logic [7:0]                      ioctl_data,
  input  logic [NUM_PORTS-1:0]            port_req,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] port_q,
  output logic [NUM_PORTS-1:0]            port_valid,
  output logic                            overflow,
  output logic [ADDR_WIDTH-1:0]           sdram_addr,
  output logic [DATA_WIDTH-1:0]           sdram_data,
  output logic                            sdram_we,
  output logic                            sdram_req,
  input  logic                            sdram_ack,
  input  logic                            sdram_valid,
  input  logic [DATA_WIDTH-1:0]           sdram_q
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_WAIT_VALID} state_t;

  state_t                          r_state;
  logic [DATA_WIDTH-1:0]           r_buf;
  logic [3:0]                      r_lanes;
  logic [ADDR_WIDTH-1:0]           r_buf_addr;
  logic [ADDR_WIDTH-1:0]           r_wr_addr;
  logic [DATA_WIDTH-1:0]           r_wr_data;
  logic                            r_pending;
  logic                            r_overflow;
  logic                            r_dl_q;
  logic [PW-1:0]                   r_rr;
  logic [PW-1:0]                   r_grant;
  logic [NUM_PORTS*DATA_WIDTH-1:0] r_port_q;
  logic [NUM_PORTS-1:0]            r_port_valid;
  logic [ADDR_WIDTH-1:0]           r_sdram_addr;
  logic [DATA_WIDTH-1:0]           r_sdram_data;
  logic                            r_sdram_we;
  logic                            r_sdram_req;

  logic [1:0]            w_lane;
  logic                  w_byte_wr;
  logic                  w_full;
  logic                  w_flush;
  logic [DATA_WIDTH-1:0] w_merge;
  logic [ADDR_WIDTH-1:0] w_word_addr;
  logic                  w_wr_done;
  logic                  w_deliver;
  logic                  w_any;
  logic [PW-1:0]         w_pick;
  logic [PW-1:0]         w_rr_next;

  assign w_lane      = ioctl_addr[1:0];
  assign w_byte_wr   = ioctl_download && ioctl_wr;
  assign w_full      = w_byte_wr && (w_lane == 2'd3);
  assign w_flush     = r_dl_q && !ioctl_download && (r_lanes != 4'd0);
  assign w_word_addr = w_full ? ioctl_addr[ADDR_WIDTH+1:2] : r_buf_addr;
  assign w_wr_done   = (r_state == S_WRITE) && sdram_ack;
  // ack+valid together in READ is handled as ack followed immediately by valid
  assign w_deliver   = ((r_state == S_READ) && sdram_ack && sdram_valid) ||
                       ((r_state == S_WAIT_VALID) && sdram_valid);
  assign w_rr_next   = (r_grant == PW'(NUM_PORTS - 1)) ? '0 : r_grant + 1'b1;

  always_comb begin
    w_merge = r_buf;
    if (w_byte_wr) w_merge[8*w_lane +: 8] = ioctl_data;
  end

  // First requesting port at or after the round-robin pointer
  always_comb begin
    int unsigned v_idx;
    v_idx  = 0;
    w_any  = 1'b0;
    w_pick = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      v_idx = 32'(r_rr) + i;
      if (v_idx >= NUM_PORTS) v_idx = v_idx - NUM_PORTS;
      if (!w_any && port_req[v_idx]) begin
        w_any  = 1'b1;
        w_pick = PW'(v_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf      <= '0;
      r_lanes    <= '0;
      r_buf_addr <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_pending  <= 1'b0;
      r_overflow <= 1'b0;
      r_dl_q     <= 1'b0;
    end else begin
      r_dl_q <= ioctl_download;
      if (w_wr_done) r_pending <= 1'b0;
      if (w_full || w_flush) begin
        if (r_pending) begin
          r_overflow <= 1'b1;
        end else begin
          r_pending <= 1'b1;
          r_wr_addr <= w_word_addr;
          r_wr_data <= w_merge;
        end
        r_buf   <= '0;
        r_lanes <= '0;
      end else if (w_byte_wr) begin
        r_buf           <= w_merge;
        r_lanes[w_lane] <= 1'b1;
        r_buf_addr      <= ioctl_addr[ADDR_WIDTH+1:2];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_rr         <= '0;
      r_grant      <= '0;
      r_port_q     <= '0;
      r_port_valid <= '0;
      r_sdram_addr <= '0;
      r_sdram_data <= '0;
      r_sdram_we   <= 1'b0;
      r_sdram_req  <= 1'b0;
    end else begin
      r_port_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (r_pending) begin
            r_state      <= S_WRITE;
            r_sdram_we   <= 1'b1;
            r_sdram_req  <= 1'b1;
            r_sdram_addr <= r_wr_addr;
            r_sdram_data <= r_wr_data;
          end else if (!ioctl_download && w_any) begin
            r_state      <= S_READ;
            r_sdram_we   <= 1'b0;
            r_sdram_req  <= 1'b1;
            r_sdram_addr <= port_addr[w_pick*ADDR_WIDTH +: ADDR_WIDTH];
            r_grant      <= w_pick;
          end
        end
        S_WRITE: begin
          if (sdram_ack) begin
            r_sdram_req <= 1'b0;
            r_sdram_we  <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        S_READ: begin
          if (sdram_ack) begin
            r_sdram_req <= 1'b0;
            if (!sdram_valid) r_state <= S_WAIT_VALID;
          end
        end
        S_WAIT_VALID: ;
        default: r_state <= S_IDLE;
      endcase
      if (w_deliver) begin
        r_port_q[r_grant*DATA_WIDTH +: DATA_WIDTH] <= sdram_q;
        r_port_valid[r_grant] <= 1'b1;
        r_rr    <= w_rr_next;
        r_state <= S_IDLE;
      end
    end
  end

  assign port_q     = r_port_q;
  assign port_valid = r_port_valid;
  assign overflow   = r_overflow;
  assign sdram_addr = r_sdram_addr;
  assign sdram_data = r_sdram_data;
  assign sdram_we   = r_sdram_we;
  assign sdram_req  = r_sdram_req;

endmodule
